// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- decode-side handshake bundle for the hazard/halt controller.
//
// Optional feature macro: HAZARD_PERF_EN (adds CNT_W and the stall_cnt signal).
//
// Signals (direction as seen by hazard_ctrl, modport slave):
//   d_valid                    in   decode latch holds a real, non-NOP instruction
//   d_rs, d_rt, d_rd           in   register ids in decode
//   d_rs_use/d_rt_use/d_rd_use in   instruction reads that register
//   d_wr                       in   instruction writes d_rd
//   d_halt                     in   instruction is HALT
//   x_flush                    in   registered execute flush (taken branch)
//   stall                      out  freeze fetch/decode and decode/execute latches
//   issue                      out  decode instruction advances this cycle
//   halted                     out  core halted
//   pending                    out  scoreboard, bit r set while a write to r is in flight
//   inflight                   out  number of valid shadow tags (0..3)
//   stall_cnt                  out  saturating count of RUN stall cycles (HAZARD_PERF_EN)
// The master modport is the decode/pipeline side that drives the instruction fields.

interface hazard_ctrl_if #(
   parameter int NREG = 16
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 16
`endif
);
   localparam int RID_W = $clog2(NREG);

   logic             d_valid;
   logic [RID_W-1:0] d_rs;
   logic [RID_W-1:0] d_rt;
   logic [RID_W-1:0] d_rd;
   logic             d_rs_use;
   logic             d_rt_use;
   logic             d_rd_use;
   logic             d_wr;
   logic             d_halt;
   logic             x_flush;
   logic             stall;
   logic             issue;
   logic             halted;
   logic [NREG-1:0]  pending;
   logic [1:0]       inflight;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   modport master (
      output d_valid, d_rs, d_rt, d_rd, d_rs_use, d_rt_use, d_rd_use,
             d_wr, d_halt, x_flush,
      input  stall, issue, halted, pending, inflight
`ifdef HAZARD_PERF_EN
      , input stall_cnt
`endif
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_rd, d_rs_use, d_rt_use, d_rd_use,
             d_wr, d_halt, x_flush,
      output stall, issue, halted, pending, inflight
`ifdef HAZARD_PERF_EN
      , output stall_cnt
`endif
   );

endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and halt controller for the five-stage core.
//
// Sits beside decode. Keeps a register scoreboard fed by a shadow tag pipeline
// (tE, tM, tW) mirroring execute, memory and writeback, raises stall on RAW/WAW
// hazards, squashes the execute tag on a branch flush and sequences the halt
// drain (RUN -> DRAIN -> HALTED).
//
// Optional feature macro: HAZARD_PERF_EN (saturating stall_cnt of RUN stalls).
//
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  asynchronous, active-low reset; clears all state
//   bus   hazard_ctrl_if.slave -- decode fields in; stall, issue, halted,
//         pending, inflight (and stall_cnt) out

module hazard_ctrl #(
   parameter int NREG = 16
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);

   localparam int RID_W = $clog2(NREG);

   typedef struct packed {
      logic             valid;
      logic             wr;
      logic [RID_W-1:0] rd;
   } tagT;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } stateT;

   tagT             tE, tM, tW;
   tagT             eNext, mNext, wNext;
   logic [NREG-1:0] pendQ, pendNext;
   logic [1:0]      inflightQ, inflightNext;
   stateT           state, stateNext;

   logic            wbWrite;
   logic [NREG-1:0] bypassMask;
   logic [NREG-1:0] hazMask;
   logic            rsHit, rtHit, rdHit, hazard;
   logic            stall, issue;

   // The register file is write-through, so the writer sitting in writeback
   // already delivers its value and must not hold up a reader or a new writer.
   assign wbWrite = tW.valid & tW.wr;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      bypassMask = '0;
      if (wbWrite) bypassMask[tW.rd] = 1'b1;
   end

   assign hazMask = pendQ & ~bypassMask;
   assign rsHit   = bus.d_rs_use & hazMask[bus.d_rs];
   assign rtHit   = bus.d_rt_use & hazMask[bus.d_rt];
   assign rdHit   = (bus.d_rd_use | bus.d_wr) & hazMask[bus.d_rd];
   assign hazard  = bus.d_valid & (rsHit | rtHit | rdHit);

   // A flush always lets the pipe move (the decode instruction is squashed);
   // otherwise DRAIN/HALTED freeze decode unconditionally.
   always_comb begin
      stall = 1'b0;
      if (!bus.x_flush) stall = (state != RUN) | hazard;
   end

   assign issue = bus.d_valid & ~stall & ~bus.x_flush & (state == RUN);

   // Next state for tags, scoreboard, drain FSM and tag count.
   always_comb begin
      stateNext = state;
      wNext     = tM;
      mNext     = bus.x_flush ? '0 : tE;
      eNext     = '0;
      pendNext  = pendQ;

      // Clears first, then the set, so a new writer targeting tW.rd wins.
      if (wbWrite) pendNext[tW.rd] = 1'b0;
      if (bus.x_flush && tE.valid && tE.wr) pendNext[tE.rd] = 1'b0;

      // HALT enters no tag: it writes nothing and the drain only waits for
      // the instructions ahead of it.
      if (issue && !bus.d_halt) begin
         eNext = tagT'{valid: 1'b1, wr: bus.d_wr, rd: bus.d_rd};
         if (bus.d_wr) pendNext[bus.d_rd] = 1'b1;
      end

      case (state)
         RUN:     if (issue && bus.d_halt) stateNext = DRAIN;
         DRAIN:   if (inflightQ == 2'd0) stateNext = HALTED;
         HALTED:  stateNext = HALTED;
         default: stateNext = RUN;
      endcase

      inflightNext = {1'b0, eNext.valid} + {1'b0, mNext.valid} + {1'b0, wNext.valid};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: pending is a small flop vector, not a RAM, so it is cleared by
   // reset in one step like any other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         tE        <= '0;
         tM        <= '0;
         tW        <= '0;
         pendQ     <= '0;
         inflightQ <= '0;
      end else begin
         state     <= stateNext;
         tE        <= eNext;
         tM        <= mNext;
         tW        <= wNext;
         pendQ     <= pendNext;
         inflightQ <= inflightNext;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stallCnt;

   // Only hazard stalls in RUN are counted; drain/halt freezes are not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt <= '0;
      end else if (stall && (state == RUN) && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   assign bus.stall_cnt = stallCnt;
`else
   // Counter absent: stall cycles are not recorded.
`endif

   assign bus.stall    = stall;
   assign bus.issue    = issue;
   assign bus.halted   = (state == HALTED);
   assign bus.pending  = pendQ;
   assign bus.inflight = inflightQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
//
// A table of {decode inputs, expected outputs} records is applied one per
// cycle; each record's expectation is queued when the inputs are driven and
// popped when the outputs are sampled mid-cycle. Hand-written sequences cover
// reset, asynchronous reset during the drain and a HALT squashed by a flush.
// With HAZARD_PERF_EN defined the stall counter is also checked.

module tb_hazard_ctrl;

   typedef struct {
      logic        valid;
      logic [3:0]  rs, rt, rd;
      logic [2:0]  uses;       // {rs, rt, rd} use bits
      logic        wr, halt, flush;
      logic        eStall, eIssue;
      logic [15:0] ePend;
      logic [1:0]  eInfl;
      logic        eHalted;
   } vecT;

   logic clk = 1'b0;
   logic rst;
   int   nChecks = 0;
   int   nPass   = 0;
   vecT  tbl[$];
   vecT  sb[$];
   int   haltIdx;
   int   runStalls;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.NREG(16)) bus ();
   hazard_ctrl #(.NREG(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic vecT v(input int valid, rs, rt, rd, uses, wr, halt, flush,
                             eStall, eIssue, ePend, eInfl, eHalted);
      vecT t;
      t.valid   = 1'(valid);
      t.rs      = 4'(rs);
      t.rt      = 4'(rt);
      t.rd      = 4'(rd);
      t.uses    = 3'(uses);
      t.wr      = 1'(wr);
      t.halt    = 1'(halt);
      t.flush   = 1'(flush);
      t.eStall  = 1'(eStall);
      t.eIssue  = 1'(eIssue);
      t.ePend   = 16'(ePend);
      t.eInfl   = 2'(eInfl);
      t.eHalted = 1'(eHalted);
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input vecT t);
      bus.d_valid  = t.valid;
      bus.d_rs     = t.rs;
      bus.d_rt     = t.rt;
      bus.d_rd     = t.rd;
      bus.d_rs_use = t.uses[2];
      bus.d_rt_use = t.uses[1];
      bus.d_rd_use = t.uses[0];
      bus.d_wr     = t.wr;
      bus.d_halt   = t.halt;
      bus.x_flush  = t.flush;
   endtask

   task automatic compareOut(input string tag);
      vecT e;
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, " stall"},    32'(bus.stall),    32'(e.eStall));
      check({tag, " issue"},    32'(bus.issue),    32'(e.eIssue));
      check({tag, " pending"},  32'(bus.pending),  32'(e.ePend));
      check({tag, " inflight"}, 32'(bus.inflight), 32'(e.eInfl));
      check({tag, " halted"},   32'(bus.halted),   32'(e.eHalted));
   endtask

   // Drive 1 after the rising edge, sample 3 later (well before the next edge).
   task automatic applyVec(input vecT t, input string tag);
      @(posedge clk);
      #1;
      drive(t);
      sb.push_back(t);
      #3;
      compareOut(tag);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, " stall"},    32'(bus.stall),    32'd0);
      check({tag, " issue"},    32'(bus.issue),    32'd0);
      check({tag, " halted"},   32'(bus.halted),   32'd0);
      check({tag, " pending"},  32'(bus.pending),  32'd0);
      check({tag, " inflight"}, 32'(bus.inflight), 32'd0);
`ifdef HAZARD_PERF_EN
      check({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
`endif
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // args: valid rs rt rd uses wr halt flush | stall issue pending inflight halted
      // Back-to-back dependency on r3.
      tbl.push_back(v(1, 0, 0, 3, 3'b000, 1, 0, 0,  0, 1, 'h0000, 0, 0)); // 0
      tbl.push_back(v(1, 3, 0, 0, 3'b100, 0, 0, 0,  1, 0, 'h0008, 1, 0)); // 1
      tbl.push_back(v(1, 3, 0, 0, 3'b100, 0, 0, 0,  1, 0, 'h0008, 1, 0)); // 2
      tbl.push_back(v(1, 3, 0, 0, 3'b100, 0, 0, 0,  0, 1, 'h0008, 1, 0)); // 3
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 1, 0)); // 4
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 1, 0)); // 5
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 1, 0)); // 6
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 0, 0)); // 7
      // Independent writers: no stalls, three tags in flight.
      tbl.push_back(v(1, 0, 0, 1, 3'b000, 1, 0, 0,  0, 1, 'h0000, 0, 0)); // 8
      tbl.push_back(v(1, 0, 0, 2, 3'b000, 1, 0, 0,  0, 1, 'h0002, 1, 0)); // 9
      tbl.push_back(v(1, 0, 0, 4, 3'b000, 1, 0, 0,  0, 1, 'h0006, 2, 0)); // 10
      tbl.push_back(v(1, 0, 0, 6, 3'b000, 1, 0, 0,  0, 1, 'h0016, 3, 0)); // 11
      tbl.push_back(v(1, 0, 0, 8, 3'b000, 1, 0, 0,  0, 1, 'h0054, 3, 0)); // 12
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0150, 3, 0)); // 13
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0140, 2, 0)); // 14
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0100, 1, 0)); // 15
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 0, 0)); // 16
      // Flush squashes the r5 writer in tE; the r10 writer in tM survives.
      tbl.push_back(v(1, 0, 0, 10, 3'b000, 1, 0, 0, 0, 1, 'h0000, 0, 0)); // 17
      tbl.push_back(v(1, 0, 0, 5, 3'b000, 1, 0, 0,  0, 1, 'h0400, 1, 0)); // 18
      tbl.push_back(v(1, 5, 0, 9, 3'b100, 1, 0, 1,  0, 0, 'h0420, 2, 0)); // 19
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0400, 1, 0)); // 20
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 0, 0)); // 21
      // Writeback bypass on r7 (set wins), then a WAW stall on r7.
      tbl.push_back(v(1, 0, 0, 7, 3'b000, 1, 0, 0,  0, 1, 'h0000, 0, 0)); // 22
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0080, 1, 0)); // 23
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0080, 1, 0)); // 24
      tbl.push_back(v(1, 7, 0, 7, 3'b100, 1, 0, 0,  0, 1, 'h0080, 1, 0)); // 25
      tbl.push_back(v(1, 0, 0, 7, 3'b000, 1, 0, 0,  1, 0, 'h0080, 1, 0)); // 26
      tbl.push_back(v(1, 0, 0, 7, 3'b000, 1, 0, 0,  1, 0, 'h0080, 1, 0)); // 27
      tbl.push_back(v(1, 0, 0, 7, 3'b000, 1, 0, 0,  0, 1, 'h0080, 1, 0)); // 28
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0080, 1, 0)); // 29
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0080, 1, 0)); // 30
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0080, 1, 0)); // 31
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 0, 0)); // 32
      // Use bits: unused rs ignored, rt hazard, store (rd use) bypassed.
      tbl.push_back(v(1, 0, 0, 12, 3'b000, 1, 0, 0, 0, 1, 'h0000, 0, 0)); // 33
      tbl.push_back(v(1, 12, 1, 0, 3'b010, 0, 0, 0, 0, 1, 'h1000, 1, 0)); // 34
      tbl.push_back(v(1, 0, 12, 0, 3'b010, 0, 0, 0, 1, 0, 'h1000, 2, 0)); // 35
      tbl.push_back(v(1, 0, 0, 12, 3'b001, 0, 0, 0, 0, 1, 'h1000, 2, 0)); // 36
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 2, 0)); // 37
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 1, 0)); // 38
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 1, 0)); // 39
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 'h0000, 0, 0)); // 40
      // Invalid decode slot never stalls even on a pending source.
      tbl.push_back(v(1, 0, 0, 13, 3'b000, 1, 0, 0, 0, 1, 'h0000, 0, 0)); // 41
      tbl.push_back(v(0, 13, 0, 0, 3'b100, 0, 0, 0, 0, 0, 'h2000, 1, 0)); // 42
      // Halt with two writers in flight; flush inside DRAIN; HALTED holds.
      tbl.push_back(v(1, 0, 0, 2, 3'b000, 1, 0, 0,  0, 1, 'h2000, 1, 0)); // 43
      tbl.push_back(v(1, 0, 0, 3, 3'b000, 1, 0, 0,  0, 1, 'h2004, 2, 0)); // 44
      haltIdx = tbl.size();
      tbl.push_back(v(1, 0, 0, 0, 3'b000, 0, 1, 0,  0, 1, 'h000C, 2, 0)); // 45
      tbl.push_back(v(1, 0, 0, 9, 3'b000, 1, 0, 0,  1, 0, 'h000C, 2, 0)); // 46
      tbl.push_back(v(1, 0, 0, 9, 3'b000, 1, 0, 1,  0, 0, 'h0008, 1, 0)); // 47
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  1, 0, 'h0000, 0, 0)); // 48
      tbl.push_back(v(0, 0, 0, 0, 3'b000, 0, 0, 0,  1, 0, 'h0000, 0, 1)); // 49
      tbl.push_back(v(1, 0, 0, 9, 3'b000, 1, 0, 1,  0, 0, 'h0000, 0, 1)); // 50
      tbl.push_back(v(1, 0, 0, 9, 3'b000, 1, 0, 0,  1, 0, 'h0000, 0, 1)); // 51

      // Reset and reset-state checks.
      rst = 1'b0;
      drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #2;
      checkResetOutputs("reset");
      @(negedge clk);
      rst = 1'b1;

      runStalls = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         applyVec(tbl[i], $sformatf("vec%0d", i));
         if (i <= haltIdx && tbl[i].eStall) runStalls++;
      end
`ifdef HAZARD_PERF_EN
      check("stall_cnt after table", 32'(bus.stall_cnt), 32'(runStalls));
`endif

      // Leave HALTED through reset, then reset asynchronously mid-DRAIN.
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      checkResetOutputs("reset from halted");
      @(negedge clk);
      rst = 1'b1;
      applyVec(v(1, 0, 0, 6, 3'b000, 1, 0, 0, 0, 1, 'h0000, 0, 0), "drain w6");
      applyVec(v(1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 1, 'h0040, 1, 0), "drain halt");
      applyVec(v(1, 0, 0, 9, 3'b000, 1, 0, 0, 1, 0, 'h0040, 1, 0), "drain stall");
      @(posedge clk);
      #2;
      rst = 1'b0;
      bus.d_valid = 1'b0;
      #1;
      checkResetOutputs("reset mid-drain");
      @(negedge clk);
      rst = 1'b1;

      // HALT squashed by a flush keeps the FSM in RUN.
      applyVec(v(1, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 'h0000, 0, 0), "halt flushed");
      applyVec(v(1, 0, 0, 1, 3'b000, 1, 0, 0, 0, 1, 'h0000, 0, 0), "run after flush");
      applyVec(v(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 'h0002, 1, 0), "run idle");

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and halt controller for the five-stage core (fetch, decode, execute, memory, writeback). Sits beside the decode stage and generates the `Stall` that freezes the fetch/decode and decode/execute latches. It keeps a register scoreboard fed by a shadow tag pipeline that mirrors execute, memory and writeback. It squashes tags on a branch flush and sequences the halt drain.

## Interface
Parameters:
- `NREG`, 16: architectural registers; register ids are `$clog2(NREG)` = 4 bits.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state.
- `d_valid`  in  1  decode latch holds a real, non-NOP instruction.
- `d_rs`, `d_rt`, `d_rd`  in  4 each  register ids in decode.
- `d_rs_use`, `d_rt_use`, `d_rd_use`  in  1 each  instruction reads that register (`d_rd_use` covers stores and branches).
- `d_wr`  in  1  instruction writes `d_rd`.
- `d_halt`  in  1  instruction is HALT.
- `x_flush`  in  1  taken-branch flush; same signal that redirects fetch (the registered execute flush).
- `stall`  out  1  freeze the fetch/decode and decode/execute latches; insert a bubble into execute.
- `issue`  out  1  the decode instruction advances this cycle.
- `halted`  out  1  core halted.
- `pending`  out  NREG  scoreboard: bit r is set while a write to r is in flight.
- `inflight`  out  2  count of valid shadow tags (0..3).
- `stall_cnt`  out  CNT_W  present only with `HAZARD_PERF_EN`.

## Operation
- Shadow tags `tE`, `tM`, `tW` each hold {valid, wr, rd}. Every clock: `tW`<=`tM`, `tM`<=`tE`, and `tE`<= `issue` ? {1,`d_wr`,`d_rd`} : 0.
- Scoreboard: a bit is set at the clock edge when `issue & d_wr`. It is cleared at the edge where `tW` (valid, wr) leaves writeback. Only one outstanding write per register is possible because WAW stalls.
- Hazard: `stall` is raised when `d_valid` is set and any used source, or `d_rd` when `d_wr` is set, has `pending` set.
  - Exception: a match on `tW.rd` with `tW` valid and writing does not stall, because the register file is write-through.
- `issue` = `d_valid & ~stall & state==RUN`.
- Flush: while `x_flush` is high:
  - `stall`=0 and `issue`=0; the decode instruction is squashed.
  - `tE` is squashed: `tM` loads 0 and the pending bit of `tE.rd` is cleared if it was writing.
  - `tM` and `tW` are unaffected.
- FSM:
  - RUN→DRAIN when a HALT issues; the HALT itself writes nothing.
  - DRAIN→HALTED when `inflight`==0.
  - HALTED is terminal until `rst`.
  - In DRAIN and HALTED, `stall`=1 except when `x_flush` is high. A flush in DRAIN does not leave DRAIN.
- A HALT in decode while `x_flush` is high is squashed and the FSM stays in RUN.
- Simultaneous set and clear of the same register bit in one cycle: set wins. This only arises for a new writer whose target equals `tW.rd`.

## Timing
- Reset values: `stall`=0, `issue`=0 (combinational, gated by `d_valid`), `halted`=0, `pending`=0, `inflight`=0, `stall_cnt`=0, FSM=RUN, all tags invalid.
- `stall`, `issue`: combinational from inputs and registered state, same cycle.
- `pending`, `inflight`, `halted`: registered. `halted` rises one cycle after `inflight` reaches 0 in DRAIN.
- A producer issued at edge N sets `pending` at N. It is in `tW` after edge N+2. A dependent issues in the cycle after edge N+2 (two stall cycles back-to-back).
- Asynchronous `rst` mid-drain returns to RUN with an empty scoreboard immediately.

## Configuration
- `HAZARD_PERF_EN` defined: `stall_cnt` counts cycles with `stall`=1 in state RUN. It saturates at all-ones and resets to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Back-to-back dependency: r3 writer then an r3 reader in decode -> `stall`=1 for exactly 2 cycles, reader issues on the 3rd, `pending[3]` clears as the writer leaves writeback.
- Independent stream of writers to r1, r2, r4 -> `stall` never asserted, `inflight` climbs to 3 and holds.
- Flush: writer to r5 in `tE`, `x_flush`=1 -> `pending[5]`=0 next cycle, `issue`=0, `stall`=0, `inflight` drops accordingly.
- Halt: HALT issued with 2 tags in flight -> DRAIN, `stall`=1, `halted`=1 three cycles later and held.
- WAW plus writeback bypass: writer to r7 in `tW`, new reader/writer of r7 in decode -> no stall, `pending[7]` stays 1.
- Reset mid-DRAIN -> all outputs at reset values; with `HAZARD_PERF_EN`, `stall_cnt` reads 0.
